div_iter_csa: RTL and testbench



---
 rtl/div_iter_csa.sv | 183 ++++++++++++++++++
 tb/tb_div_iter_csa.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_csa.sv
// Multi-cycle restoring unsigned divider, STEP quotient bits per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN to add the signed_i port and the FIX state for truncating signed division.
module div_iter_csa #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             dz_o
`ifdef DIV_SIGNED_EN
    ,
    input  logic             signed_i
`endif
);

    // state | meaning
    // IDLE  | waiting for operands
    // CALC  | STEP restoring sub-steps per cycle, then result capture
    // FIX   | sign correction of magnitudes (signed build only)
    // DONE  | result presented until out_ready_i
    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
`ifdef DIV_SIGNED_EN
        FIX  = 2'd3,
`endif
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] aq_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] pr_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;

    logic [WIDTH-1:0] pr_nx;
    logic [WIDTH-1:0] aq_nx;
    logic [WIDTH:0]   tmp;
    logic [WIDTH+1:0] diff;
    logic             spare_unused;

`ifdef DIV_SIGNED_EN
    logic             sgn_q;
    logic             qneg_q;
    logic             rneg_q;
    logic [WIDTH-1:0] a_orig_q;
    logic             a_neg;
    logic             b_neg;

    assign a_neg = signed_i & dividend_i[WIDTH-1];
    assign b_neg = signed_i & divisor_i[WIDTH-1];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_d = CALC;
            end
            CALC: begin
                if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
                    state_d = sgn_q ? FIX : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef DIV_SIGNED_EN
            FIX: state_d = DONE;
`endif
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Partial remainder gets one extra bit so the trial subtract never overflows.
    always_comb begin
        pr_nx        = pr_q;
        aq_nx        = aq_q;
        tmp          = '0;
        diff         = '0;
        spare_unused = 1'b0;
        for (int s = 0; s < STEP; s++) begin
            tmp          = {pr_nx, aq_nx[WIDTH-1]};
            diff         = {1'b0, tmp} - {2'b00, b_q};
            spare_unused = spare_unused | diff[WIDTH];
            pr_nx        = diff[WIDTH+1] ? tmp[WIDTH-1:0] : diff[WIDTH-1:0];
            aq_nx        = {aq_nx[WIDTH-2:0], ~diff[WIDTH+1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            aq_q     <= '0;
            b_q      <= '0;
            pr_q     <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q    <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            a_orig_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        pr_q  <= '0;
                        cnt_q <= CW'(N);
                        dz_q  <= (divisor_i == '0);
`ifdef DIV_SIGNED_EN
                        aq_q     <= a_neg ? -dividend_i : dividend_i;
                        b_q      <= b_neg ? -divisor_i : divisor_i;
                        sgn_q    <= signed_i;
                        qneg_q   <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        a_orig_q <= dividend_i;
`else
                        aq_q <= dividend_i;
                        b_q  <= divisor_i;
`endif
                    end
                end
                CALC: begin
                    if (cnt_q != '0) begin
                        pr_q  <= pr_nx;
                        aq_q  <= aq_nx;
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        quot_q <= aq_q;
                        rem_q  <= pr_q;
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    if (dz_q) begin
                        quot_q <= '1;
                        rem_q  <= a_orig_q;
                    end else begin
                        quot_q <= qneg_q ? -aq_q : aq_q;
                        rem_q  <= rneg_q ? -pr_q : pr_q;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;
    assign dz_o   = dz_q;

endmodule

// File: tb/tb_div_iter_csa.sv
// Directed bench for div_iter_csa: vector table at WIDTH=32/STEP=1 plus backpressure,
// mid-division reset, a STEP=4 instance, and signed cases when DIV_SIGNED_EN is defined.
module tb_div_iter_csa;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, dz;
    logic [31:0] quot, rem;

    logic        v4 = 1'b0;
    logic [31:0] a4 = '0;
    logic [31:0] b4 = '0;
    logic        ir4, ov4, dz4;
    logic [31:0] q4, rm4;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    div_iter_csa #(.WIDTH(32), .STEP(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .dividend_i(a), .divisor_i(b),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .quot_o(quot), .rem_o(rem), .dz_o(dz)
`ifdef DIV_SIGNED_EN
        , .signed_i(sgn)
`endif
    );

    div_iter_csa #(.WIDTH(32), .STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(v4), .in_ready_o(ir4),
        .dividend_i(a4), .divisor_i(b4),
        .out_valid_o(ov4), .out_ready_i(1'b1),
        .quot_o(q4), .rem_o(rm4), .dz_o(dz4)
`ifdef DIV_SIGNED_EN
        , .signed_i(1'b0)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic launch(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 100);
    endtask

    initial begin
        int lat;
        logic [31:0] hq, hr;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[2] = '{32'd5,          32'hFFFF_FFFF,  32'd0,          32'd5,          1'b0};
        vecs[3] = '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[4] = '{32'd1000,       32'd1000,       32'd1,          32'd0,          1'b0};
        vecs[5] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0};

        #12;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_quot", quot, 32'd0);
        check("reset_rem", rem, 32'd0);
        check("reset_dz", {31'b0, dz}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_valid(lat);
            check($sformatf("vec%0d_latency", i), lat, 32'd33);
            check($sformatf("vec%0d_quot", i), quot, vecs[i].q);
            check($sformatf("vec%0d_rem", i), rem, vecs[i].r);
            check($sformatf("vec%0d_dz", i), {31'b0, dz}, {31'b0, vecs[i].dz});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid_drop", i), {31'b0, out_valid}, 32'd0);
            check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
        end

        // Backpressure: result held for 10 cycles while in_valid pulses are ignored.
        out_ready = 1'b0;
        launch(32'h1234_5678, 32'h100);
        wait_valid(lat);
        check("bp_latency", lat, 32'd33);
        hq = quot;
        hr = rem;
        check("bp_quot", hq, 32'h0012_3456);
        check("bp_rem", hr, 32'h78);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 32'd999 + i;
            b = 32'd3;
            @(posedge clk);
            #1;
            check("bp_valid_held", {31'b0, out_valid}, 32'd1);
            check("bp_quot_held", quot, 32'h0012_3456);
            check("bp_rem_held", rem, 32'h78);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {31'b0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("bp_no_spurious_accept", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of an iteration.
        launch(32'hFFFF, 32'd3);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_quot", quot, 32'd0);
        check("midrst_rem", rem, 32'd0);
        check("midrst_dz", {31'b0, dz}, 32'd0);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        launch(32'd200, 32'd9);
        wait_valid(lat);
        check("postrst_latency", lat, 32'd33);
        check("postrst_quot", quot, 32'd22);
        check("postrst_rem", rem, 32'd2);
        @(posedge clk);
        #1;

        // STEP=4 instance: N=8, latency 9.
        @(negedge clk);
        a4 = 32'd200;
        b4 = 32'd9;
        v4 = 1'b1;
        @(posedge clk);
        #1 v4 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov4 && lat < 100);
        check("step4_latency", lat, 32'd9);
        check("step4_quot", q4, 32'd22);
        check("step4_rem", rm4, 32'd2);
        check("step4_dz", {31'b0, dz4}, 32'd0);
        @(posedge clk);
        #1;
        check("step4_in_ready", {31'b0, ir4}, 32'd1);

`ifdef DIV_SIGNED_EN
        sgn = 1'b1;
        launch(32'hFFFF_FFF9, 32'd2);
        wait_valid(lat);
        check("s_m7d2_latency", lat, 32'd34);
        check("s_m7d2_quot", quot, 32'hFFFF_FFFD);
        check("s_m7d2_rem", rem, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        launch(32'h8000_0000, 32'hFFFF_FFFF);
        wait_valid(lat);
        check("s_minneg_quot", quot, 32'h8000_0000);
        check("s_minneg_rem", rem, 32'd0);
        check("s_minneg_dz", {31'b0, dz}, 32'd0);
        @(posedge clk);
        #1;
        launch(32'd7, 32'hFFFF_FFFE);
        wait_valid(lat);
        check("s_7dm2_quot", quot, 32'hFFFF_FFFD);
        check("s_7dm2_rem", rem, 32'd1);
        @(posedge clk);
        #1;
        launch(32'hFFFF_FFF9, 32'd0);
        wait_valid(lat);
        check("s_dz_quot", quot, 32'hFFFF_FFFF);
        check("s_dz_rem", rem, 32'hFFFF_FFF9);
        check("s_dz_flag", {31'b0, dz}, 32'd1);
        @(posedge clk);
        #1;
        sgn = 1'b0;
        launch(32'hFFFF_FFF9, 32'd2);
        wait_valid(lat);
        check("u_in_sbuild_latency", lat, 32'd33);
        check("u_in_sbuild_quot", quot, 32'h7FFF_FFFC);
        check("u_in_sbuild_rem", rem, 32'd1);
        @(posedge clk);
        #1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
